// File: rtl/fp_mantissa_alu_pipe.sv
// fp_mantissa_alu_pipe: two-stage sign-magnitude mantissa add/subtract with valid/ready flow control.
// Revision 1.0 - initial pipelined release.
`default_nettype none

module fp_mantissa_alu_pipe #(
  parameter int MANT_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_bypass,
  input  logic              in_sub,
  input  logic              in_sign_a,
  input  logic              in_sign_b,
  input  logic [MANT_W-1:0] in_mant_a,
  input  logic [MANT_W-1:0] in_mant_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic              out_carry,
  output logic              out_sign,
  output logic              out_zero,
  output logic              out_bypass
);

  logic              r_s1_valid;
  logic              r_s1_bypass;
  logic              r_s1_sign_a;
  logic              r_s1_eff_sign_b;
  logic              r_s1_eff_sub;
  logic              r_s1_b_gt_a;
  logic [MANT_W-1:0] r_s1_mant_a;
  logic [MANT_W-1:0] r_s1_mant_b;

  logic              w_advance;
  logic              w_accept;
  logic              w_eff_sign_b;
  logic [MANT_W:0]   w_sum;
  logic [MANT_W-1:0] w_diff;
  logic [MANT_W-1:0] w_mant;
  logic              w_carry;
  logic              w_sign;
  logic              w_zero;

  assign w_advance    = !out_valid || out_ready;
  assign in_ready     = w_advance || !r_s1_valid;
  assign w_accept     = in_valid && in_ready;
  assign w_eff_sign_b = in_sign_b ^ in_sub;

  // Stage 1: capture operands and precompute the add/sub decision and magnitude order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid      <= 1'b0;
      r_s1_bypass     <= 1'b0;
      r_s1_sign_a     <= 1'b0;
      r_s1_eff_sign_b <= 1'b0;
      r_s1_eff_sub    <= 1'b0;
      r_s1_b_gt_a     <= 1'b0;
      r_s1_mant_a     <= '0;
      r_s1_mant_b     <= '0;
    end else if (w_accept) begin
      r_s1_valid      <= 1'b1;
      r_s1_bypass     <= in_bypass;
      r_s1_sign_a     <= in_sign_a;
      r_s1_eff_sign_b <= w_eff_sign_b;
      r_s1_eff_sub    <= in_sign_a ^ w_eff_sign_b;
      r_s1_b_gt_a     <= (in_mant_b > in_mant_a);
      r_s1_mant_a     <= in_mant_a;
      r_s1_mant_b     <= in_mant_b;
    end else if (w_advance) begin
      r_s1_valid      <= 1'b0;
    end
  end

  assign w_sum  = {1'b0, r_s1_mant_a} + {1'b0, r_s1_mant_b};
  assign w_diff = r_s1_b_gt_a ? (r_s1_mant_b - r_s1_mant_a) : (r_s1_mant_a - r_s1_mant_b);

  // Subtraction is always larger minus smaller; exact cancellation yields +0.
  always_comb begin
    w_mant  = '0;
    w_carry = 1'b0;
    w_sign  = 1'b0;
    if (r_s1_bypass) begin
      w_mant  = '0;
      w_carry = 1'b0;
      w_sign  = 1'b0;
    end else if (!r_s1_eff_sub) begin
      {w_carry, w_mant} = w_sum;
      w_sign            = r_s1_sign_a;
    end else begin
      w_mant = w_diff;
      if (w_diff == '0) begin
        w_sign = 1'b0;
      end else begin
        w_sign = r_s1_b_gt_a ? r_s1_eff_sign_b : r_s1_sign_a;
      end
    end
  end

  assign w_zero = !r_s1_bypass && (w_mant == '0) && !w_carry;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_mant   <= '0;
      out_carry  <= 1'b0;
      out_sign   <= 1'b0;
      out_zero   <= 1'b0;
      out_bypass <= 1'b0;
    end else if (w_advance) begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        out_mant   <= w_mant;
        out_carry  <= w_carry;
        out_sign   <= w_sign;
        out_zero   <= w_zero;
        out_bypass <= r_s1_bypass;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp_mantissa_alu_pipe.sv
// tb_fp_mantissa_alu_pipe: scoreboard bench for the pipelined mantissa ALU (MANT_W = 24).
`default_nettype none

module tb_fp_mantissa_alu_pipe;

  localparam int W = 24;

  typedef struct packed {
    logic         bp;
    logic         zero;
    logic         sign;
    logic         carry;
    logic [W-1:0] mant;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, in_bypass, in_sub, in_sign_a, in_sign_b;
  logic [W-1:0] in_mant_a, in_mant_b;
  logic         out_valid, out_ready, out_carry, out_sign, out_zero, out_bypass;
  logic [W-1:0] out_mant;

  fp_mantissa_alu_pipe #(.MANT_W(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_bypass(in_bypass), .in_sub(in_sub),
    .in_sign_a(in_sign_a), .in_sign_b(in_sign_b), .in_mant_a(in_mant_a), .in_mant_b(in_mant_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_mant(out_mant), .out_carry(out_carry),
    .out_sign(out_sign), .out_zero(out_zero), .out_bypass(out_bypass)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  exp_t sb_q[$];
  int   pop_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Independent reference: signed integer arithmetic, then split into sign/magnitude.
  function automatic exp_t model(input logic bp, input logic sub, input logic sa, input logic sb,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint va, vb, r, mag;
    e = '0;
    if (bp) begin
      e.bp = 1'b1;
      return e;
    end
    va  = sa ? -longint'(a) : longint'(a);
    vb  = (sb ^ sub) ? -longint'(b) : longint'(b);
    r   = va + vb;
    mag = (r < 0) ? -r : r;
    e.mant  = mag[W-1:0];
    e.carry = mag[W];
    e.sign  = (r < 0);
    if (r == 0 && sa == (sb ^ sub)) e.sign = sa;
    e.zero = (mag == 0);
    return e;
  endfunction

  task automatic set_in(input logic bp, input logic sub, input logic sa, input logic sb,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    in_bypass = bp; in_sub = sub; in_sign_a = sa; in_sign_b = sb;
    in_mant_a = a;  in_mant_b = b;
  endtask

  // Presents one operand set and returns just after the accepting edge.
  task automatic send(input logic bp, input logic sub, input logic sa, input logic sb,
                      input logic [W-1:0] a, input logic [W-1:0] b, input logic use_hand,
                      input exp_t hand);
    bit done = 0;
    @(negedge clk);
    set_in(bp, sub, sa, sb, a, b);
    in_valid = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      #1;
      if (in_ready) begin
        sb_q.push_back(use_hand ? hand : model(bp, sub, sa, sb, a, b));
        @(posedge clk);
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 40 && sb_q.size() != 0; t++) @(negedge clk);
    chk(name, 64'(sb_q.size()), 64'd0);
  endtask

  // Monitor: compares each transferred result against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_output", {out_bypass, out_zero, out_sign, out_carry, out_mant}, 64'd0);
          if ({out_bypass, out_zero, out_sign, out_carry, out_mant} == '0)
            chk("unexpected_output_valid", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("result", {out_bypass, out_zero, out_sign, out_carry, out_mant}, e);
          pop_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n0, acc, idx;
    logic [W+3:0] snap;
    logic [W-1:0] va[4], vb[4];
    logic         vs[4];

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_in(0, 0, 0, 0, '0, '0);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_outputs", {out_bypass, out_zero, out_sign, out_carry, out_mant}, 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Latency: accepted at edge k, visible after edge k+1.
    send(0, 0, 0, 0, 24'h800000, 24'h800000, 1, '{bp:0, zero:0, sign:0, carry:1, mant:24'h000000});
    @(negedge clk); in_valid = 1'b0;
    #1 chk("latency_k", 64'(out_valid), 64'd0);
    @(negedge clk);
    #1 chk("latency_k1", 64'(out_valid), 64'd1);

    send(0, 1, 0, 0, 24'h900000, 24'hC00000, 1, '{bp:0, zero:0, sign:1, carry:0, mant:24'h300000});
    send(0, 0, 1, 0, 24'hABCDEF, 24'hABCDEF, 1, '{bp:0, zero:1, sign:0, carry:0, mant:24'h000000});
    send(0, 0, 1, 1, 24'h000000, 24'h000000, 1, '{bp:0, zero:1, sign:1, carry:0, mant:24'h000000});
    send(0, 0, 0, 0, 24'hFFFFFF, 24'hFFFFFF, 1, '{bp:0, zero:0, sign:0, carry:1, mant:24'hFFFFFE});
    send(0, 1, 1, 1, 24'h123456, 24'h023456, 1, '{bp:0, zero:0, sign:1, carry:0, mant:24'h100000});
    send(1, 0, 1, 0, 24'h654321, 24'h123456, 1, '{bp:1, zero:0, sign:0, carry:0, mant:24'h000000});
    idle();
    drain("drain_directed");

    // Back-to-back stream: results must appear on consecutive cycles.
    n0 = pop_cyc.size();
    for (int i = 0; i < 8; i++)
      send(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           W'($urandom), W'($urandom), 0, '0);
    idle();
    drain("drain_stream");
    chk("stream_count", 64'(pop_cyc.size() - n0), 64'd8);
    if (pop_cyc.size() - n0 == 8)
      chk("stream_consecutive", 64'(pop_cyc[n0+7] - pop_cyc[n0]), 64'd7);

    // Stall: out_ready low for 5 cycles with in_valid held.
    for (int i = 0; i < 4; i++) begin
      va[i] = W'($urandom); vb[i] = W'($urandom); vs[i] = 1'($urandom_range(0, 1));
    end
    acc = 0; idx = 0; snap = '0;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_in(0, vs[idx], 0, 1, va[idx], vb[idx]);
      #1;
      if (i == 3) snap = {out_bypass, out_zero, out_sign, out_carry, out_mant};
      if (in_ready) begin
        sb_q.push_back(model(0, vs[idx], 0, 1, va[idx], vb[idx]));
        acc++;
        idx++;
      end
      @(negedge clk);
    end
    #1;
    chk("stall_accepts", 64'(acc), 64'd2);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    chk("stall_out_valid", 64'(out_valid), 64'd1);
    chk("stall_stable", {out_bypass, out_zero, out_sign, out_carry, out_mant}, snap);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain("drain_stall");

    // Reset with both stages occupied.
    send(0, 0, 0, 0, 24'h111111, 24'h222222, 0, '0);
    send(0, 0, 0, 0, 24'h333333, 24'h444444, 0, '0);
    #2;
    reset = 1'b1;
    #1;
    sb_q.delete();
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_outputs", {out_bypass, out_zero, out_sign, out_carry, out_mant}, 64'd0);
    chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 chk("rst_no_stale", 64'(out_valid), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fp_mantissa_alu_pipe.md
# fp_mantissa_alu_pipe

Pipelined, parametrised sign-magnitude mantissa add/subtract unit for the FP adder datapath, positioned between the alignment stage and the normaliser. It replaces the single-cycle combinational mantissa ALU with a two-stage registered datapath. It adds:
- a valid/ready handshake with backpressure;
- an explicit subtract operation;
- a zero-result flag with canonical +0 sign;
- pass-through of the bypass flag so downstream stages stay in step.

## Interface
Parameters:
- MANT_W, 24, aligned mantissa width in bits (hidden bit plus guard bits included); legal range 4..64.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- in_valid  input  1  upstream operand set valid
- in_ready  output  1  unit can accept an operand set this cycle
- in_bypass  input  1  special case (NaN/Inf/zero) handled elsewhere; no arithmetic
- in_sub  input  1  1 = compute A − B (B sign inverted), 0 = A + B
- in_sign_a  input  1  sign of A
- in_sign_b  input  1  sign of B
- in_mant_a  input  MANT_W  aligned mantissa A, unsigned
- in_mant_b  input  MANT_W  aligned mantissa B, unsigned
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_mant  output  MANT_W  result magnitude
- out_carry  output  1  carry out of magnitude add
- out_sign  output  1  result sign
- out_zero  output  1  out_mant == 0 and out_carry == 0
- out_bypass  output  1  registered copy of in_bypass

## Operation
- **Stage 1 (S1) register**, loaded on accept. It holds:
  - the operands and in_bypass;
  - eff_sign_b = in_sign_b XOR in_sub;
  - eff_sub = in_sign_a XOR eff_sign_b;
  - b_gt_a = (in_mant_b > in_mant_a), registered.
- **Stage 2 / output register**, loaded from S1:
  - bypass=1: out_mant=0, out_carry=0, out_sign=0, out_zero=0, out_bypass=1.
  - eff_sub=0: {out_carry,out_mant} = A + B (MANT_W+1 bits, no truncation); out_sign = sign_a.
  - eff_sub=1, b_gt_a=1: out_mant = B − A; out_sign = eff_sign_b; out_carry=0.
  - eff_sub=1, b_gt_a=0: out_mant = A − B; out_sign = sign_a; out_carry=0.
  - Exact cancellation (eff_sub=1, A==B): out_mant=0, out_sign=0 (+0), out_zero=1.
  - Addition with both mantissas zero: out_zero=1, out_sign = sign_a (−0 + −0 = −0).
- Subtraction never produces a borrow or underflow; the magnitude is always larger minus smaller.
- Control:
  - advance = !out_valid || out_ready;
  - in_ready = advance || !s1_valid.
- Accept = in_valid && in_ready.
- S1 → out transfer occurs when advance && s1_valid.
- If advance && !s1_valid, out_valid clears at the edge.
- S1 behaviour:
  - accepts new data when in_ready;
  - holds its data when !advance;
  - otherwise clears s1_valid if nothing is accepted.
- The unit never drops or duplicates an operand set; ordering is strictly FIFO.

## Timing
- Reset (asynchronous assert; release synchronous to clk):
  - s1_valid=0, out_valid=0, out_mant=0, out_carry=0, out_sign=0, out_zero=0, out_bypass=0;
  - in_ready=1 immediately after reset.
- Latency: an operand accepted at edge k appears with out_valid=1 after edge k+1 if there is no stall.
- Throughput: one result per cycle with out_ready held high.
- Stall behaviour:
  - out_valid && !out_ready: outputs hold stable; S1 still fills if empty, then in_ready=0 until out_ready.
  - Simultaneous accept and output transfer in the same cycle are both honoured.
- out_* are registered outputs; in_ready is combinational from out_ready, out_valid and s1_valid only.
- Reset mid-operation discards in-flight data; no result is emitted after reset.

## Test plan
- MANT_W=24, A=0x800000 (+), B=0x800000 (+), add → out_mant=0x000000, out_carry=1, out_sign=0, out_zero=0, out_valid at edge k+1.
- A=0x900000 (+), B=0xC00000 (+), in_sub=1 → out_mant=0x300000, out_sign=1, out_carry=0.
- A=0xABCDEF (−), B=0xABCDEF (+), add → out_mant=0, out_sign=0, out_zero=1.
- Back-to-back stream of 8 random sets with out_ready=1 → 8 results on consecutive cycles, in order, each matching the golden model.
- out_ready=0 for 5 cycles while in_valid=1 → exactly 2 sets accepted, in_ready=0 afterwards, outputs stable; on release the results drain in order with none lost.
- in_bypass=1 with nonzero mantissas → out_bypass=1, out_mant=0, out_zero=0. Assert reset while s1_valid=1 → all outputs 0 within the same cycle, no stale result after release.
